tnn_seq_neuron: RTL and testbench

- Parametrised, time-multiplexed successor to the fixed 4x3-bit combinational approximate TNN neuron.
- Accepts a vector of N_IN unsigned IN_W-bit features and binarises each one.
- Accumulates ternary-weighted contributions, one input per cycle, then compares the sum against a runtime bias to produce a 1-bit class decision.
- Weights and bias are runtime-loadable, so one instance serves any evolved/trained neuron in the classifier datapath.

---
 rtl/tnn_pkg.sv | 40 ++++
 rtl/tnn_weight_rf.sv | 41 ++++
 rtl/tnn_seq_neuron.sv | 138 +++++++++++++
 tb/tb_tnn_seq_neuron.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types and helpers for the time-multiplexed ternary neuron.
// Weight codes, FSM states, weight decode and feature binarisation.
package tnn_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Reserved code 2'b10 behaves as a zero weight.
  function automatic logic signed [1:0] w_decode(
    input logic [1:0] w
  );
    logic signed [1:0] v;
    v = 2'sb00;
    unique case (1'b1)
      (w == W_POS): v = 2'sb01;
      (w == W_NEG): v = 2'sb11;
      default:      v = 2'sb00;
    endcase
    return v;
  endfunction

  // Feature arrives zero-extended; w is its real width.
  function automatic logic binarise(
    input logic [31:0] f,
    input int          w,
    input logic        mode
  );
    logic msb;
    msb = 1'(f >> (w - 1));
    return mode ? (f != 32'd0) : msb;
  endfunction

endpackage

// File: rtl/tnn_weight_rf.sv
// Ternary weight register file for tnn_seq_neuron.
// Writes are refused while the neuron is busy or the index is invalid.
module tnn_weight_rf
  import tnn_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int AW = $clog2(N_IN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic          i_busy,
  input  logic [AW-1:0] i_addr,
  input  logic [1:0]    i_wdata,
  input  logic [AW-1:0] i_rd_idx,
  output logic [1:0]    o_rdata,
  output logic          o_err
);

  logic [1:0] r_w [N_IN];
  logic       w_in_range;
  logic       w_rd_ok;
  logic       w_wr;

  assign w_in_range = (32'(i_addr) < 32'(N_IN));
  assign w_rd_ok    = (32'(i_rd_idx) < 32'(N_IN));
  assign w_wr       = i_we & ~i_busy & w_in_range;
  assign o_err      = i_we & (i_busy | ~w_in_range);
  assign o_rdata    = w_rd_ok ? r_w[i_rd_idx] : W_ZERO;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        r_w[i] <= W_ZERO;
      end
    end else if (w_wr) begin
      r_w[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/tnn_seq_neuron.sv
// Sequential ternary neuron: one weighted input per cycle,
// then a signed compare of the sum against a loadable bias.
module tnn_seq_neuron
  import tnn_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int IN_W     = 3,
  parameter int BIN_MODE = 0,
  parameter int ACC_W    = $clog2(N_IN + 1) + 1,
  localparam int AW = $clog2(N_IN),
  localparam int IW = $clog2(N_IN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*IN_W-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit,
  input  logic                    cfg_w_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [1:0]              cfg_wdata,
  input  logic                    cfg_b_we,
  input  logic signed [ACC_W-1:0] cfg_bdata,
  output logic                    cfg_err
);

  state_e                  r_state;
  state_e                  w_next;
  logic [N_IN*IN_W-1:0]    r_vec;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_bias;
  logic [IW-1:0]           r_idx;
  logic                    r_out_bit;
  logic                    r_cfg_err;

  logic                    w_busy;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_w_err;
  logic                    w_bin;
  logic [AW-1:0]           w_rd_idx;
  logic [1:0]              w_wcode;
  logic [IN_W-1:0]         w_feat;
  logic signed [1:0]       w_contrib;
  logic [ACC_W-1:0]        w_contrib_x;

  assign w_busy   = (r_state != IDLE);
  assign w_accept = in_valid & in_ready;
  // One extra ACC cycle at idx == N_IN registers the decision.
  assign w_last   = (r_idx == IW'(N_IN));
  assign w_rd_idx = r_idx[AW-1:0];
  assign w_feat   = r_vec[w_rd_idx*IN_W +: IN_W];
  assign w_bin    = binarise(32'(w_feat), IN_W, BIN_MODE != 0);

  assign w_contrib = (w_bin && !w_last) ? w_decode(w_wcode)
                                        : 2'sb00;
  assign w_contrib_x = {{(ACC_W-2){w_contrib[1]}}, w_contrib};

  tnn_weight_rf #(
    .N_IN (N_IN)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (cfg_w_we),
    .i_busy   (w_busy),
    .i_addr   (cfg_addr),
    .i_wdata  (cfg_wdata),
    .i_rd_idx (w_rd_idx),
    .o_rdata  (w_wcode),
    .o_err    (w_w_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = ACC;
      ACC:     if (w_last) w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (r_state == IDLE): in_ready = rst_n;
      (r_state == OUT):  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec     <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_out_bit <= 1'b0;
    end else if (w_accept) begin
      r_vec <= in_data;
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == ACC) begin
      if (w_last) begin
        r_out_bit <= (r_acc >= r_bias);
      end else begin
        r_acc <= r_acc + $signed(w_contrib_x);
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bias    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (cfg_b_we && !w_busy) begin
        r_bias <= cfg_bdata;
      end
      r_cfg_err <= w_w_err | (cfg_b_we & w_busy);
    end
  end

  assign out_bit = r_out_bit;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_tnn_seq_neuron.sv
// Directed bench for tnn_seq_neuron, N_IN=4, IN_W=3.
// A second instance with BIN_MODE=1 shares all inputs.
module tb_tnn_seq_neuron;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic        out_ready;
  logic        cfg_w_we;
  logic [1:0]  cfg_addr;
  logic [1:0]  cfg_wdata;
  logic        cfg_b_we;
  logic [3:0]  cfg_bdata;

  logic in_ready, out_valid, out_bit, cfg_err;
  logic in_ready1, out_valid1, out_bit1, cfg_err1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tnn_seq_neuron #(
    .N_IN (4), .IN_W (3), .BIN_MODE (0)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .cfg_w_we  (cfg_w_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_b_we  (cfg_b_we),
    .cfg_bdata (cfg_bdata),
    .cfg_err   (cfg_err)
  );

  tnn_seq_neuron #(
    .N_IN (4), .IN_W (3), .BIN_MODE (1)
  ) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_bit   (out_bit1),
    .cfg_w_we  (cfg_w_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_b_we  (cfg_b_we),
    .cfg_bdata (cfg_bdata),
    .cfg_err   (cfg_err1)
  );

  task automatic wr_w(input logic [1:0] a, input logic [1:0] d);
    cfg_w_we  = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk); #1;
    cfg_w_we = 1'b0;
  endtask

  task automatic wr_all(input logic [1:0] d);
    for (int i = 0; i < 4; i++) wr_w(2'(i), d);
  endtask

  task automatic wr_b(input logic [3:0] d);
    cfg_b_we  = 1'b1;
    cfg_bdata = d;
    @(posedge clk); #1;
    cfg_b_we = 1'b0;
  endtask

  // Called just after a posedge with out_ready=1.
  task automatic run_vec(input logic [11:0] d, output logic ob,
                         output logic ob1, output int lat);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_w_we = 1'b0;
    cfg_b_we = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    ob  = out_bit;
    ob1 = out_bit1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic ob, ob1;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({in_ready, in_ready1} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_in_ready: got %b required 00",
               {in_ready, in_ready1});
    end
    n_chk++;
    if (out_valid !== 1'b0 || out_bit !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out: valid=%0b bit=%0b required 0 0",
               out_valid, out_bit);
    end
    n_chk++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cfg_err: got %0b required 0", cfg_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_in_ready: got %0b required 1", in_ready);
    end
    run_vec(12'hFFF, ob, ob1, lat);
    n_chk++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL latency: got %0d required 5", lat);
    end
    n_chk++;
    if (ob !== 1'b1) begin
      n_fail++;
      $display("FAIL default_bit: got %0b required 1", ob);
    end
  endtask

  task automatic test_weights;
    logic ob, ob1;
    int lat;
    wr_w(2'd1, 2'b01);
    wr_w(2'd2, 2'b11);
    wr_w(2'd3, 2'b11);
    wr_w(2'd0, 2'b00);
    // b=4 only: acc=+1
    run_vec(12'h020, ob, ob1, lat);
    n_chk++;
    if (ob !== 1'b1) begin
      n_fail++;
      $display("FAIL w_pos: got %0b required 1", ob);
    end
    // b=c=d=4: acc=-1
    run_vec(12'h920, ob, ob1, lat);
    n_chk++;
    if (ob !== 1'b0) begin
      n_fail++;
      $display("FAIL w_neg: got %0b required 0", ob);
    end
  endtask

  task automatic test_backpressure;
    int n;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 12'h020;
    @(posedge clk); #1;
    in_data = 12'h920;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_valid: got %0b required 1", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({out_valid, out_bit, in_ready} !== 3'b110) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v/b/rdy=%b required 110",
                 i, {out_valid, out_bit, in_ready});
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release: rdy/v=%b required 10",
               {in_ready, out_valid});
    end
  endtask

  task automatic test_cfg_busy;
    logic ob, ob1;
    int lat;
    int n;
    in_valid = 1'b1;
    in_data  = 12'h020;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cfg_w_we  = 1'b1;
    cfg_addr  = 2'd1;
    cfg_wdata = 2'b11;
    @(posedge clk); #1;
    cfg_w_we = 1'b0;
    n_chk++;
    if ({cfg_err, cfg_err1} !== 2'b11) begin
      n_fail++;
      $display("FAIL busy_err: got %b required 11",
               {cfg_err, cfg_err1});
    end
    @(posedge clk); #1;
    n_chk++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_err_pulse: got %0b required 0", cfg_err);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (out_valid !== 1'b1 || out_bit !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_inflight: v=%0b b=%0b required 1 1",
               out_valid, out_bit);
    end
    @(posedge clk); #1;
    run_vec(12'h020, ob, ob1, lat);
    n_chk++;
    if (ob !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_w_kept: got %0b required 1", ob);
    end
    // acc=+1 against the bias 2 written on the accept edge
    cfg_b_we  = 1'b1;
    cfg_bdata = 4'd2;
    run_vec(12'h020, ob, ob1, lat);
    n_chk++;
    if (ob !== 1'b0) begin
      n_fail++;
      $display("FAIL bias_same_cycle: got %0b required 0", ob);
    end
    wr_b(4'd0);
  endtask

  task automatic test_bias_bounds;
    logic ob, ob1;
    int lat;
    logic [3:0] bias_t [4];
    logic [1:0] w_t    [4];
    logic       exp_t  [4];
    bias_t = '{4'd4, 4'd5, 4'hC, 4'hD};
    w_t    = '{2'b01, 2'b01, 2'b11, 2'b11};
    exp_t  = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      wr_all(w_t[i]);
      wr_b(bias_t[i]);
      run_vec(12'hFFF, ob, ob1, lat);
      n_chk++;
      if (ob !== exp_t[i]) begin
        n_fail++;
        $display("FAIL bias_bound[%0d]: got %0b required %0b",
                 i, ob, exp_t[i]);
      end
    end
  endtask

  task automatic reset_mid(input logic [11:0] d);
    logic seen;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | out_valid | out_valid1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_valid: got %0b required 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    logic ob, ob1;
    int lat;
    wr_all(2'b11);
    wr_b(4'd1);
    reset_mid(12'hFFF);
    run_vec(12'hFFF, ob, ob1, lat);
    n_chk++;
    if (ob !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst_clear: got %0b required 1", ob);
    end
    // 3'b001 features: MSB mode sees 0, OR mode sees 1
    wr_all(2'b01);
    wr_b(4'd1);
    run_vec(12'h249, ob, ob1, lat);
    n_chk++;
    if ({ob, ob1} !== 2'b01) begin
      n_fail++;
      $display("FAIL bin_mode: got %b required 01", {ob, ob1});
    end
    reset_mid(12'h249);
    run_vec(12'h249, ob, ob1, lat);
    n_chk++;
    if ({ob, ob1} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_rst_mode1: got %b required 11", {ob, ob1});
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cfg_w_we  = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    cfg_b_we  = 1'b0;
    cfg_bdata = '0;
    test_reset();
    test_weights();
    test_backpressure();
    test_cfg_busy();
    test_bias_bounds();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
